// File: rtl/sprite_line_fetcher_if.sv
// Pattern-memory read port for the sprite line fetcher.
// One outstanding read at a time; ack carries the read data.
interface sprite_line_fetcher_if #(
  parameter int ADDR_W = 16
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/sprite_line_fetcher.sv
// Fetches one pattern row per sprite during hblank, loads the
// shift registers, then paces per-sprite shift enables by X.
module sprite_line_fetcher #(
  parameter int                ADDR_W       = 16,
  parameter logic [ADDR_W-1:0] PATTERN_BASE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  hblank_start,
  input  logic                  pixel_tick,
  input  logic [3:0]            sprite_count,
  input  logic [7:0][7:0]       sprite_tile,
  input  logic [7:0][3:0]       sprite_row,
  input  logic [7:0][7:0]       sprite_x,
  sprite_line_fetcher_if.master mem,
  output logic [7:0][31:0]      load_data,
  output logic                  load_sprite,
  output logic [7:0]            enable,
  output logic                  fetch_done,
  output logic                  fetch_overrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_LOAD,
    S_ACTIVE
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [3:0]        n_in;
  logic [3:0]        n_q;
  logic [2:0]        idx;
  logic [7:0][31:0]  staging;
  logic [7:0][7:0]   xcnt;
  logic [7:0][4:0]   rem;
  logic              start;
  logic              last;
  logic              shift;
  logic [ADDR_W-1:0] fetch_addr;

  assign n_in  = (sprite_count > 4'd8) ? 4'd8 : sprite_count;
  assign start = hblank_start &&
                 (state == S_IDLE || state == S_ACTIVE);
  assign last  = ({1'b0, idx} + 4'd1) == n_q;
  assign shift = (state == S_ACTIVE) && pixel_tick &&
                 !hblank_start;

  // tile*16 + row is just {tile,row} since row < 16
  assign fetch_addr = PATTERN_BASE +
    ADDR_W'({sprite_tile[idx], sprite_row[idx]});

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE, S_ACTIVE:
        if (hblank_start)
          state_nx = (n_in == 4'd0) ? S_LOAD : S_FETCH;
      S_FETCH:
        state_nx = S_WAIT;
      S_WAIT:
        if (mem.mem_ack)
          state_nx = last ? S_LOAD : S_FETCH;
      S_LOAD:
        state_nx = S_ACTIVE;
      default:
        state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    enable = '0;
    if (shift) begin
      for (int i = 0; i < 8; i++)
        enable[i] = (xcnt[i] == 8'd0) && (rem[i] != 5'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      n_q           <= '0;
      idx           <= '0;
      staging       <= '0;
      load_data     <= '0;
      load_sprite   <= 1'b0;
      fetch_done    <= 1'b0;
      fetch_overrun <= 1'b0;
      mem.mem_req   <= 1'b0;
      mem.mem_addr  <= '0;
      xcnt          <= '0;
      rem           <= '0;
    end else begin
      load_sprite <= (state == S_LOAD);
      fetch_done  <= (state == S_LOAD);
      if (hblank_start && !start)
        fetch_overrun <= 1'b1;
      if (start) begin
        n_q     <= n_in;
        idx     <= '0;
        staging <= '0;
      end
      if (state == S_FETCH) begin
        mem.mem_req  <= 1'b1;
        mem.mem_addr <= fetch_addr;
      end
      // req drops after ack so a FETCH cycle always separates reads
      if (state == S_WAIT && mem.mem_ack) begin
        mem.mem_req  <= 1'b0;
        staging[idx] <= mem.mem_rdata;
        idx          <= idx + 3'd1;
      end
      if (state == S_LOAD) begin
        load_data <= staging;
        for (int i = 0; i < 8; i++) begin
          xcnt[i] <= sprite_x[i];
          rem[i]  <= (i < int'(n_q)) ? 5'd16 : 5'd0;
        end
      end
      if (shift) begin
        for (int i = 0; i < 8; i++) begin
          if (xcnt[i] != 8'd0)
            xcnt[i] <= xcnt[i] - 8'd1;
          else if (rem[i] != 5'd0)
            rem[i] <= rem[i] - 5'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sprite_line_fetcher.sv
// Randomized bench for sprite_line_fetcher with a line-level
// reference model and a single per-cycle compare process.
module tb_sprite_line_fetcher;
  localparam int          ADDR_W = 16;
  localparam logic [15:0] PB     = 16'h0000;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             hblank_start = 1'b0;
  logic             pixel_tick = 1'b0;
  logic [3:0]       sprite_count = '0;
  logic [7:0][7:0]  sprite_tile = '0;
  logic [7:0][3:0]  sprite_row = '0;
  logic [7:0][7:0]  sprite_x = '0;
  logic [7:0][31:0] load_data;
  logic             load_sprite;
  logic [7:0]       enable;
  logic             fetch_done;
  logic             fetch_overrun;

  sprite_line_fetcher_if #(.ADDR_W(ADDR_W)) mem ();

  sprite_line_fetcher #(
    .ADDR_W(ADDR_W),
    .PATTERN_BASE(PB)
  ) dut (
    .clk(clk),
    .reset(rst),
    .hblank_start(hblank_start),
    .pixel_tick(pixel_tick),
    .sprite_count(sprite_count),
    .sprite_tile(sprite_tile),
    .sprite_row(sprite_row),
    .sprite_x(sprite_x),
    .mem(mem),
    .load_data(load_data),
    .load_sprite(load_sprite),
    .enable(enable),
    .fetch_done(fetch_done),
    .fetch_overrun(fetch_overrun)
  );

  always #5 clk = ~clk;

  // controls written only by the stimulus process
  int          slave_dly = -1;
  bit          slave_hold = 1'b0;
  bit          late_ack_req = 1'b0;
  bit          use_fixed = 1'b0;
  logic [31:0] fixed_rdata [2];
  bit          pa = 1'b0;
  bit          pe = 1'b0;
  bit          pc = 1'b0;
  int          tmo_cnt = 0;

  // memory slave: random or fixed latency, one-cycle ack
  bit s_busy;
  int s_wc, s_d, s_fi;
  always @(posedge clk) begin
    #1;
    if (!use_fixed) s_fi = 0;
    if (rst) begin
      mem.mem_ack   = 1'b0;
      mem.mem_rdata = '0;
      s_busy        = 1'b0;
    end else if (mem.mem_ack) begin
      mem.mem_ack = 1'b0;
    end else if (late_ack_req) begin
      mem.mem_ack   = 1'b1;
      mem.mem_rdata = $urandom;
    end else if (slave_hold) begin
      s_busy = 1'b0;
    end else if (mem.mem_req) begin
      if (!s_busy) begin
        s_busy = 1'b1;
        s_wc   = 0;
        s_d    = (slave_dly < 0) ? int'($urandom_range(0, 4))
                                 : slave_dly;
      end
      if (s_wc == s_d) begin
        mem.mem_ack   = 1'b1;
        mem.mem_rdata = use_fixed ? fixed_rdata[s_fi & 1]
                                  : $urandom;
        s_fi++;
        s_busy = 1'b0;
      end else begin
        s_wc++;
      end
    end
  end

  // reference model state, owned by the compare process
  int               checks = 0;
  int               errors = 0;
  bit               busy, active, jr, ovr_q;
  int               c_n, reads, reqc, cyc, tick_no, line_n;
  int               tmo_seen = 0;
  logic [7:0][31:0] exp_words;
  logic [7:0][7:0]  line_x;
  logic [7:0]       exp_en;
  logic             p_req, p_ack;
  logic [15:0]      p_addr;
  logic [15:0]      pin_a [2];
  logic [2:0]       ri;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      busy   = 1'b0;
      active = 1'b0;
      ovr_q  = 1'b0;
      p_req  = 1'b0;
      p_ack  = 1'b0;
      reads  = 0;
      jr     = 1'b1;
    end else begin
      if (jr) begin
        chk("rst_req", mem.mem_req, 0);
        chk("rst_load", load_sprite, 0);
        chk("rst_done", fetch_done, 0);
        chk("rst_ovr", fetch_overrun, 0);
        chk("rst_en", enable, 0);
        for (int i = 0; i < 8; i++)
          chk("rst_data", load_data[i], 0);
        jr = 1'b0;
      end
      if (tmo_cnt != tmo_seen) begin
        chk("load_timeout", tmo_seen, tmo_cnt);
        tmo_seen = tmo_cnt;
      end
      if (busy) cyc++;
      chk("overrun", fetch_overrun, ovr_q);
      chk("done_eq_load", fetch_done, load_sprite);
      if (load_sprite) begin
        chk("load_expected", busy, 1);
        if (busy) begin
          chk("load_latency", cyc, 2 + reads + reqc);
          chk("read_count", reads, c_n);
          for (int i = 0; i < 8; i++)
            chk("load_data", load_data[i], exp_words[i]);
          if (pa) begin
            chk("pin_data0", load_data[0], 32'hA5A5A5A5);
            chk("pin_data1", load_data[1], 32'h12345678);
          end
          if (pc) chk("pin_reads8", reads, 8);
          busy    = 1'b0;
          active  = 1'b1;
          tick_no = 0;
          line_x  = sprite_x;
          line_n  = c_n;
        end
      end
      if (mem.mem_req) begin
        if (!p_req) begin
          chk("req_in_fetch", busy && reads < c_n, 1);
          if (busy && reads < c_n) begin
            ri = 3'(reads);
            chk("addr", mem.mem_addr,
                16'(int'(PB) + int'(sprite_tile[ri]) * 16 +
                    int'(sprite_row[ri])));
            if (pa && reads < 2)
              chk("pin_addr", mem.mem_addr, pin_a[reads]);
          end
        end else begin
          chk("req_gap", p_ack, 0);
          chk("addr_stable", mem.mem_addr, p_addr);
        end
        if (busy) reqc++;
        if (busy && mem.mem_ack && reads < 8) begin
          exp_words[3'(reads)] = mem.mem_rdata;
          reads++;
        end
      end else if (p_req && !p_ack) begin
        chk("req_held", mem.mem_req, 1);
      end
      for (int i = 0; i < 8; i++)
        exp_en[i] = active && pixel_tick && !hblank_start &&
                    i < line_n && tick_no >= int'(line_x[i]) &&
                    tick_no < int'(line_x[i]) + 16;
      chk("enable", enable, exp_en);
      if (pe && active && pixel_tick)
        chk("pin_enable", enable,
            {6'b0, tick_no >= 10 && tick_no < 26, tick_no < 16});
      if (active && pixel_tick && !hblank_start) tick_no++;
      if (hblank_start) begin
        if (busy) begin
          ovr_q = 1'b1;
        end else begin
          busy      = 1'b1;
          active    = 1'b0;
          c_n       = (sprite_count > 4'd8) ? 8 : int'(sprite_count);
          reads     = 0;
          reqc      = 0;
          cyc       = 0;
          exp_words = '0;
        end
      end
      p_req  = mem.mem_req;
      p_ack  = mem.mem_ack;
      p_addr = mem.mem_addr;
    end
  end

  task automatic run_line(input int cnt, input int dly,
                          input int ntick, input int ovr_k,
                          input bit hb_tick, input bit keep);
    int k;
    bit seen;
    @(posedge clk); #1;
    if (!keep) begin
      for (int i = 0; i < 8; i++) begin
        sprite_tile[i] = 8'($urandom);
        sprite_row[i]  = 4'($urandom);
        sprite_x[i]    = 8'($urandom);
      end
    end
    sprite_count = 4'(cnt);
    slave_dly    = dly;
    hblank_start = 1'b1;
    pixel_tick   = hb_tick;
    k = 0;
    seen = 1'b0;
    while (!seen && k < 400) begin
      @(posedge clk); #1;
      k++;
      hblank_start = (k == ovr_k);
      pixel_tick   = 1'b0;
      @(negedge clk);
      seen = load_sprite;
    end
    if (!seen) begin
      $display("FAIL load_wait: no load_sprite within %0d cycles", k);
      tmo_cnt++;
    end
    for (int t = 0; t < ntick; t++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
        pixel_tick = 1'b0;
      end
      @(posedge clk); #1;
      pixel_tick = 1'b1;
    end
    @(posedge clk); #1;
    pixel_tick = 1'b0;
  endtask

  initial begin
    int k;
    pin_a[0]       = 16'h0035;
    pin_a[1]       = 16'h010F;
    fixed_rdata[0] = 32'hA5A5A5A5;
    fixed_rdata[1] = 32'h12345678;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);

    run_line(0, -1, 256, 0, 0, 0);

    sprite_tile[0] = 8'h03; sprite_row[0] = 4'h5;
    sprite_tile[1] = 8'h10; sprite_row[1] = 4'hF;
    sprite_x[0]    = 8'd0;  sprite_x[1]   = 8'd10;
    use_fixed = 1'b1;
    pa = 1'b1;
    pe = 1'b1;
    run_line(2, 1, 30, 0, 0, 1);
    pa = 1'b0;
    pe = 1'b0;
    use_fixed = 1'b0;

    run_line(3, 5, 256, 0, 0, 0);

    pc = 1'b1;
    run_line(12, -1, 256, 0, 0, 0);
    pc = 1'b0;

    sprite_x = '0;
    run_line(8, -1, 5, 0, 0, 1);
    run_line(4, -1, 256, 0, 1, 0);

    for (int i = 0; i < 8; i++) begin
      sprite_tile[i] = 8'($urandom);
      sprite_row[i]  = 4'($urandom);
      sprite_x[i]    = 8'($urandom);
    end
    sprite_x[0] = 8'd0;
    sprite_x[1] = 8'd255;
    sprite_x[2] = 8'd240;
    sprite_x[3] = 8'd241;
    run_line(8, 0, 256, 0, 0, 1);

    for (int l = 0; l < 4; l++)
      run_line(int'($urandom_range(0, 12)), -1, 256, 0, 0, 0);

    run_line(3, 2, 256, 2, 0, 0);
    run_line(5, -1, 256, 0, 0, 0);

    slave_hold = 1'b1;
    @(posedge clk); #1;
    sprite_count = 4'd3;
    hblank_start = 1'b1;
    @(posedge clk); #1;
    hblank_start = 1'b0;
    k = 0;
    while (!mem.mem_req && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    late_ack_req = 1'b1;
    @(negedge clk);
    late_ack_req = 1'b0;
    slave_hold = 1'b0;
    repeat (10) @(posedge clk);

    run_line(6, -1, 256, 0, 0, 0);

    repeat (5) @(posedge clk);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
